// File: rtl/traffic_apb_arbiter_pkg.sv
// Shared types and constants for the traffic-controller APB arbiter.
package traffic_apb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess
  } apb_state_e;

  localparam logic [31:0] CTL_ADDR    = 32'h0000_0000;
  localparam logic [31:0] TIMER0_ADDR = 32'h0000_0004;
  localparam logic [31:0] TIMER1_ADDR = 32'h0000_0008;

  localparam int unsigned DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/traffic_apb_arbiter_if.sv
// APB bus bundle between the arbiter (master) and the traffic register slave.
interface traffic_apb_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/traffic_apb_arbiter_rr_arbiter.sv
// Round-robin requester selection; search starts one past the last granted index.
module rr_arbiter #(
  parameter int unsigned NREQ = 2
) (
  input  logic            pclk,
  input  logic            presetn,
  input  logic [NREQ-1:0] i_req,
  input  logic [NREQ-1:0] i_mask,
  input  logic            i_advance,
  output logic [NREQ-1:0] o_grant,
  output logic [1:0]      o_grant_id,
  output logic            o_valid
);
  logic [1:0] r_last;
  logic [3:0] w_elig;
  logic [1:0] w_idx;

  // Padded to four so the 2-bit index is always in range.
  assign w_elig = 4'(i_req & ~i_mask);

  always_comb begin
    o_valid    = 1'b0;
    o_grant_id = '0;
    w_idx      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_idx = 2'((32'(r_last) + k) % NREQ);
      if (!o_valid && w_elig[w_idx]) begin
        o_valid    = 1'b1;
        o_grant_id = w_idx;
      end
    end
  end

  assign o_grant = o_valid ? (NREQ'(1) << o_grant_id) : '0;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_last <= 2'(NREQ - 1);
    end else if (i_advance && o_valid) begin
      r_last <= o_grant_id;
    end
  end
endmodule

// File: rtl/traffic_apb_arbiter.sv
// Shares one APB slave between NREQ requesters: round-robin grant, SETUP/ACCESS, timeout abort.
module traffic_apb_arbiter
  import traffic_apb_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                     pclk,
  input  logic                     presetn,
  input  logic [NREQ-1:0]          i_req,
  input  logic [NREQ-1:0]          i_req_write,
  input  logic [NREQ*ADDR_W-1:0]   i_req_addr,
  input  logic [NREQ*DATA_W-1:0]   i_req_wdata,
  output logic [NREQ-1:0]          o_done,
  output logic [DATA_W-1:0]        o_rsp_rdata,
  output logic                     o_rsp_err,
  output logic                     o_busy,
  output logic [1:0]               o_grant_id,
  traffic_apb_if.master            apb
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  apb_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_psel, r_penable, r_pwrite, r_busy, r_rsp_err;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata, r_rsp_rdata;
  logic [NREQ-1:0]   r_done, r_grant_oh;
  logic [1:0]        r_grant_id;

  logic [NREQ-1:0]   w_grant;
  logic [1:0]        w_grant_id;
  logic              w_valid, w_advance;
  logic              w_sel_write;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  assign w_advance = (r_state == StIdle);

  // Requesters are ineligible during their own done cycle.
  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .pclk       (pclk),
    .presetn    (presetn),
    .i_req      (i_req),
    .i_mask     (r_done),
    .i_advance  (w_advance),
    .o_grant    (w_grant),
    .o_grant_id (w_grant_id),
    .o_valid    (w_valid)
  );

  always_comb begin
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (w_grant[i]) begin
        w_sel_write = i_req_write[i];
        w_sel_addr  = i_req_addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = i_req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_busy      <= 1'b0;
      r_done      <= '0;
      r_grant_oh  <= '0;
      r_grant_id  <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_done <= '0;
      unique case (r_state)
        StIdle: begin
          if (w_valid && w_advance) begin
            r_psel     <= 1'b1;
            r_busy     <= 1'b1;
            r_pwrite   <= w_sel_write;
            r_paddr    <= w_sel_addr;
            r_pwdata   <= w_sel_wdata;
            r_grant_oh <= w_grant;
            r_grant_id <= w_grant_id;
            r_state    <= StSetup;
          end
        end
        StSetup: begin
          r_penable <= 1'b1;
          r_cnt     <= '0;
          r_state   <= StAccess;
        end
        StAccess: begin
          if (apb.pready || (r_cnt == CNT_W'(TIMEOUT - 1))) begin
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= r_grant_oh;
            r_rsp_rdata <= (apb.pready && !r_pwrite) ? apb.prdata : '0;
            r_rsp_err   <= apb.pready ? apb.pslverr : 1'b1;
            r_state     <= StIdle;
          end else if (r_cnt != {CNT_W{1'b1}}) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign apb.psel    = r_psel;
  assign apb.penable = r_penable;
  assign apb.pwrite  = r_pwrite;
  assign apb.paddr   = r_paddr;
  assign apb.pwdata  = r_pwdata;
  assign o_done      = r_done;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;
  assign o_busy      = r_busy;
  assign o_grant_id  = r_grant_id;
endmodule

// File: tb/tb_traffic_apb_arbiter.sv
// Directed bench for traffic_apb_arbiter with a small traffic-register slave model.
module tb_traffic_apb_arbiter;
  import traffic_apb_pkg::*;

  localparam int unsigned NREQ = 2;

  logic                pclk;
  logic                presetn;
  logic [NREQ-1:0]     i_req;
  logic [NREQ-1:0]     i_req_write;
  logic [NREQ*32-1:0]  i_req_addr;
  logic [NREQ*32-1:0]  i_req_wdata;
  logic [NREQ-1:0]     o_done;
  logic [31:0]         o_rsp_rdata;
  logic                o_rsp_err;
  logic                o_busy;
  logic [1:0]          o_grant_id;

  traffic_apb_if #(.ADDR_W(32), .DATA_W(32)) apb ();

  traffic_apb_arbiter #(
    .NREQ    (NREQ),
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (16)
  ) u_dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .i_req       (i_req),
    .i_req_write (i_req_write),
    .i_req_addr  (i_req_addr),
    .i_req_wdata (i_req_wdata),
    .o_done      (o_done),
    .o_rsp_rdata (o_rsp_rdata),
    .o_rsp_err   (o_rsp_err),
    .o_busy      (o_busy),
    .o_grant_id  (o_grant_id),
    .apb         (apb)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  // Slave: pready in the 3rd ACCESS cycle, pslverr outside ctl/timer registers.
  logic        slave_hang;
  logic [1:0]  acc_cnt;
  logic [31:0] mem [4];
  logic        addr_ok;

  assign addr_ok = (apb.paddr == CTL_ADDR) || (apb.paddr == TIMER0_ADDR) ||
                   (apb.paddr == TIMER1_ADDR);
  assign apb.pready  = apb.psel && apb.penable && (acc_cnt == 2'd2) && !slave_hang;
  assign apb.pslverr = !addr_ok;
  assign apb.prdata  = addr_ok ? mem[apb.paddr[3:2]] : 32'hDEAD_BEEF;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      acc_cnt <= '0;
    end else if (apb.psel && apb.penable && !apb.pready) begin
      acc_cnt <= acc_cnt + 2'd1;
    end else begin
      acc_cnt <= '0;
    end
  end

  always_ff @(posedge pclk) begin
    if (apb.pready && apb.pwrite && addr_ok) mem[apb.paddr[3:2]] <= apb.pwdata;
  end

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cycle 0 is the cycle in which req rises; req drops the cycle after done.
  task automatic run_xfer(input int idx, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, output int t_sel, output int t_en,
                          output int t_done, output logic [31:0] rdata, output bit err,
                          output bit sel_at_done);
    @(posedge pclk); #1;
    i_req[idx]                = 1'b1;
    i_req_write[idx]          = wr;
    i_req_addr[idx*32 +: 32]  = addr;
    i_req_wdata[idx*32 +: 32] = wdata;
    t_sel = -1; t_en = -1; t_done = -1; rdata = '0; err = 1'b0; sel_at_done = 1'b1;
    for (int c = 0; c < 60 && t_done < 0; c++) begin
      @(negedge pclk);
      if (apb.psel && t_sel < 0) t_sel = c;
      if (apb.penable && t_en < 0) t_en = c;
      if (o_done[idx]) begin
        t_done      = c;
        rdata       = o_rsp_rdata;
        err         = o_rsp_err;
        sel_at_done = apb.psel;
      end
    end
    @(posedge pclk); #1;
    i_req[idx] = 1'b0;
  endtask

  task automatic wait_done(input int idx, output int n);
    n = -1;
    for (int c = 0; c < 60 && n < 0; c++) begin
      @(negedge pclk);
      if (o_done[idx]) n = c;
    end
  endtask

  int          t_sel, t_en, t_done, n;
  logic [31:0] rdata;
  bit          err, sel_d;
  logic [1:0]  grants [4];
  int          ndone, ngaps, gap, cnt0, cnt1;
  bit          seen;
  logic [1:0]  done_s;

  initial begin
    presetn     = 1'b0;
    slave_hang  = 1'b0;
    i_req       = '0;
    i_req_write = '0;
    i_req_addr  = '0;
    i_req_wdata = '0;
    for (int i = 0; i < 4; i++) mem[i] = 32'h0;

    @(negedge pclk);
    check_val("rst_psel",    32'(apb.psel), 0);
    check_val("rst_penable", 32'(apb.penable), 0);
    check_val("rst_pwrite",  32'(apb.pwrite), 0);
    check_val("rst_paddr",   apb.paddr, 0);
    check_val("rst_pwdata",  apb.pwdata, 0);
    check_val("rst_done",    32'(o_done), 0);
    check_val("rst_rdata",   o_rsp_rdata, 0);
    check_val("rst_err",     32'(o_rsp_err), 0);
    check_val("rst_busy",    32'(o_busy), 0);
    check_val("rst_grant",   32'(o_grant_id), 0);
    @(posedge pclk); #1;
    presetn = 1'b1;

    // Single write then read-back of timer_0.
    run_xfer(0, 1'b1, 32'h4, 32'h1234_5678, t_sel, t_en, t_done, rdata, err, sel_d);
    check_val("wr_psel_cyc", 32'(t_sel), 1);
    check_val("wr_pen_cyc",  32'(t_en), 2);
    check_val("wr_done_cyc", 32'(t_done), 5);
    check_val("wr_err",      32'(err), 0);
    check_val("wr_rdata",    rdata, 0);
    run_xfer(0, 1'b0, 32'h4, 32'h0, t_sel, t_en, t_done, rdata, err, sel_d);
    check_val("rd_done_cyc", 32'(t_done), 5);
    check_val("rd_rdata",    rdata, 32'h1234_5678);
    check_val("rd_err",      32'(err), 0);

    // Undecoded address: slave error.
    run_xfer(0, 1'b0, 32'h10, 32'h0, t_sel, t_en, t_done, rdata, err, sel_d);
    check_val("slverr_done", 32'(t_done), 5);
    check_val("slverr_err",  32'(err), 1);

    // Timeout: 16 ACCESS cycles (2..17), done in cycle 18.
    slave_hang = 1'b1;
    run_xfer(0, 1'b0, 32'h4, 32'h0, t_sel, t_en, t_done, rdata, err, sel_d);
    check_val("to_done_cyc", 32'(t_done), 18);
    check_val("to_err",      32'(err), 1);
    check_val("to_rdata",    rdata, 0);
    check_val("to_psel",     32'(sel_d), 0);
    slave_hang = 1'b0;
    run_xfer(0, 1'b1, 32'h8, 32'hA5A5_0001, t_sel, t_en, t_done, rdata, err, sel_d);
    check_val("post_to_done", 32'(t_done), 5);
    check_val("post_to_err",  32'(err), 0);

    // Reset in the 2nd ACCESS cycle of a requester-0 transfer.
    @(posedge pclk); #1;
    i_req[0] = 1'b1; i_req_write[0] = 1'b0; i_req_addr[31:0] = 32'h4;
    repeat (3) @(posedge pclk);
    #1;
    check_val("pre_rst_pen", 32'(apb.penable), 1);
    #1;
    presetn = 1'b0;
    #1;
    check_val("mid_rst_psel", 32'(apb.psel), 0);
    check_val("mid_rst_pen",  32'(apb.penable), 0);
    check_val("mid_rst_done", 32'(o_done), 0);
    check_val("mid_rst_busy", 32'(o_busy), 0);
    i_req[0] = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    presetn = 1'b1;
    @(negedge pclk);
    check_val("post_rst_done", 32'(o_done), 0);

    // Contention after reset: both held, two transfers each, expect 0,1,0,1.
    @(posedge pclk); #1;
    i_req_write = 2'b01;
    i_req_addr  = {32'h8, 32'h0};
    i_req_wdata = {32'h0, 32'h0000_0001};
    i_req       = 2'b11;
    ndone = 0; ngaps = 0; gap = 0; cnt0 = 0; cnt1 = 0; seen = 1'b0;
    for (int i = 0; i < 4; i++) grants[i] = '0;
    for (int c = 0; c < 80 && ndone < 4; c++) begin
      @(negedge pclk);
      if (apb.psel) begin
        if (seen && gap != 0) begin
          check_val("cont_gap", 32'(gap), 1);
          ngaps++;
        end
        gap  = 0;
        seen = 1'b1;
      end else if (seen) begin
        gap++;
      end
      done_s = o_done;
      if (done_s != 0) begin
        grants[ndone] = done_s;
        ndone++;
      end
      @(posedge pclk); #1;
      if (done_s[0]) begin cnt0++; if (cnt0 == 2) i_req[0] = 1'b0; end
      if (done_s[1]) begin cnt1++; if (cnt1 == 2) i_req[1] = 1'b0; end
    end
    check_val("cont_ndone", 32'(ndone), 4);
    check_val("cont_ngaps", 32'(ngaps), 3);
    check_val("cont_g0", 32'(grants[0]), 32'h1);
    check_val("cont_g1", 32'(grants[1]), 32'h2);
    check_val("cont_g2", 32'(grants[2]), 32'h1);
    check_val("cont_g3", 32'(grants[3]), 32'h2);

    // Masking: req0 held through done; next SETUP exactly 2 cycles after done.
    @(posedge pclk); #1;
    i_req_write[0]    = 1'b1;
    i_req_addr[31:0]  = 32'h4;
    i_req_wdata[31:0] = 32'h0000_0055;
    i_req[0]          = 1'b1;
    wait_done(0, n);
    check_val("mask_done1", 32'(n), 5);
    check_val("mask_psel_d0", 32'(apb.psel), 0);
    @(negedge pclk);
    check_val("mask_psel_d1", 32'(apb.psel), 0);
    @(negedge pclk);
    check_val("mask_psel_d2", 32'(apb.psel), 1);
    check_val("mask_pen_d2",  32'(apb.penable), 0);
    wait_done(0, n);
    check_val("mask_done2", 32'(n), 3);
    @(posedge pclk); #1;
    i_req[0] = 1'b0;
    repeat (3) @(posedge pclk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
